// File: rtl/io_port_sequencer_if.sv
// Control and pad-pattern signals between the bring-up sequencer and its user.
interface io_port_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] io_out;
  logic [7:0] io_oeb;
  logic       busy;
  logic       done;
  logic [3:0] step_idx;

  modport master (
    output start, abort,
    input  io_out, io_oeb, busy, done, step_idx
  );

  modport slave (
    input  start, abort,
    output io_out, io_oeb, busy, done, step_idx
  );
endinterface

// File: rtl/io_port_sequencer.sv
// Pad-ring bring-up pattern generator: walks 01..0A, FF, 00 onto mprj_io[7:0],
// holding each value HOLD_CYCLES clocks after a start pulse.
module io_port_sequencer #(
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  io_port_sequencer_if.slave bus
);

  localparam int unsigned CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned LAST_RUN = 10;
  localparam int unsigned END_IDX  = 11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       io_out;
  logic [7:0]       io_oeb;
  logic             busy;
  logic             done;
  logic [3:0]       step_idx;

  // Table value for a given index: 1..10, then FF, then 00 as terminal.
  function automatic logic [7:0] pattern(input logic [3:0] idx);
    if (idx < 4'd10)       return 8'(idx) + 8'd1;
    else if (idx == 4'd10) return 8'hFF;
    else                   return 8'h00;
  endfunction

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      hold_cnt <= '0;
      io_out   <= 8'h00;
      io_oeb   <= 8'hFF;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= 4'(END_IDX);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Abort dominates start, so a simultaneous pair leaves pads untouched.
          if (bus.start && !bus.abort) begin
            state    <= RUN;
            hold_cnt <= '0;
            io_out   <= pattern(4'd0);
            io_oeb   <= 8'h00;
            busy     <= 1'b1;
            step_idx <= 4'd0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            hold_cnt <= '0;
            io_out   <= 8'h00;
            busy     <= 1'b0;
            step_idx <= 4'(END_IDX);
          end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            if (step_idx == 4'(LAST_RUN)) begin
              state    <= IDLE;
              io_out   <= 8'h00;
              busy     <= 1'b0;
              done     <= 1'b1;
              step_idx <= 4'(END_IDX);
            end else begin
              io_out   <= pattern(4'(step_idx + 4'd1));
              step_idx <= 4'(step_idx + 4'd1);
            end
          end else begin
            hold_cnt <= CNT_W'(hold_cnt + CNT_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.io_out   = io_out;
  assign bus.io_oeb   = io_oeb;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.step_idx = step_idx;

endmodule

// File: tb/tb_io_port_sequencer.sv
// Scoreboard bench: two sequencers (HOLD 64 and HOLD 1) share start/abort and are
// compared each cycle against an elapsed-time reference model.
module tb_io_port_sequencer;

  localparam int unsigned HA = 64;
  localparam int unsigned HB = 1;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] oeb;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t sb_q[$];

  // Reference model state per instance: running flag, start edge, last outputs.
  bit   m_run [2];
  int   m_t0  [2];
  obs_t m_obs [2];
  int   m_hold[2];

  io_port_sequencer_if ifa ();
  io_port_sequencer_if ifb ();

  io_port_sequencer #(.HOLD_CYCLES(HA)) dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa.slave));
  io_port_sequencer #(.HOLD_CYCLES(HB)) dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    if (i < 10)       return 8'(i + 1);
    else if (i == 10) return 8'hFF;
    else              return 8'h00;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.out = 8'h00; o.oeb = 8'hFF; o.busy = 1'b0; o.done = 1'b0; o.idx = 4'd11;
    return o;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %02h expected %02h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_step(input int d, input logic s, input logic a, input logic r);
    int el;
    if (r) begin
      m_run[d] = 0;
      m_obs[d] = reset_obs();
      return;
    end
    m_obs[d].done = 1'b0;
    if (m_run[d]) begin
      el = edge_n - m_t0[d];
      if (a || el == 11 * m_hold[d]) begin
        m_run[d]      = 0;
        m_obs[d].out  = 8'h00;
        m_obs[d].idx  = 4'd11;
        m_obs[d].busy = 1'b0;
        m_obs[d].done = !a;
      end else begin
        m_obs[d].idx = 4'(el / m_hold[d]);
        m_obs[d].out = pat(el / m_hold[d]);
      end
    end else if (s && !a) begin
      m_run[d]      = 1;
      m_t0[d]       = edge_n;
      m_obs[d].out  = 8'h01;
      m_obs[d].oeb  = 8'h00;
      m_obs[d].busy = 1'b1;
      m_obs[d].idx  = 4'd0;
    end
  endtask

  // Drive inputs for the coming edge, then model that edge and queue the expectation.
  task automatic tick(input logic s, input logic a, input logic r);
    exp_t e;
    ifa.start = s; ifa.abort = a;
    ifb.start = s; ifb.abort = a;
    rst = r;
    @(posedge clk);
    edge_n++;
    model_step(0, s, a, r);
    model_step(1, s, a, r);
    e.a = m_obs[0];
    e.b = m_obs[1];
    sb_q.push_back(e);
    #1;
  endtask

  task automatic cmp_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, "_io_out"},   act.out,         exp.out);
    chk({tag, "_io_oeb"},   act.oeb,         exp.oeb);
    chk({tag, "_busy"},     8'(act.busy),    8'(exp.busy));
    chk({tag, "_done"},     8'(act.done),    8'(exp.done));
    chk({tag, "_step_idx"}, 8'(act.idx),     8'(exp.idx));
  endtask

  function automatic obs_t grab_a();
    obs_t o;
    o.out = ifa.io_out; o.oeb = ifa.io_oeb; o.busy = ifa.busy; o.done = ifa.done; o.idx = ifa.step_idx;
    return o;
  endfunction

  function automatic obs_t grab_b();
    obs_t o;
    o.out = ifb.io_out; o.oeb = ifb.io_oeb; o.busy = ifb.busy; o.done = ifb.done; o.idx = ifb.step_idx;
    return o;
  endfunction

  // Monitor: compares the DUT outputs against queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp_obs("h64", grab_a(), e.a);
        cmp_obs("h1",  grab_b(), e.b);
      end
    end
  end

  initial begin
    m_hold[0] = int'(HA);
    m_hold[1] = int'(HB);
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_t0[d] = 0; m_obs[d] = reset_obs();
    end
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;

    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    // Simultaneous start and abort in idle must leave pads tristated.
    tick(1'b1, 1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);

    // Full run with a redundant start while 0x06 is on the pads.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 11 * int'(HA) + 5; i++)
      tick(i == 5 * int'(HA) + 3, 1'b0, 1'b0);

    // Abort while 0x04 is held, then replay from 0x01.
    tick(1'b1, 1'b0, 1'b0);
    repeat (3 * HA + 7) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (11 * HA + 4) tick(1'b0, 1'b0, 1'b0);

    // Randomized start/abort traffic.
    for (int i = 0; i < 5000; i++)
      tick(($urandom % 16) == 0, ($urandom % 300) == 0, 1'b0);

    // Drain, then assert reset asynchronously mid-cycle while 0xFF is displayed.
    repeat (11 * HA + 2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (10 * HA + 5) tick(1'b0, 1'b0, 1'b0);
    #6;
    chk("pre_reset_io_out", ifa.io_out, 8'hFF);
    rst = 1'b1;
    #1;
    cmp_obs("async_rst_h64", grab_a(), reset_obs());
    cmp_obs("async_rst_h1",  grab_b(), reset_obs());
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
